// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture_ctrl
// Purpose  : Camera pixel-capture controller (OV7670-style bus). Runs in the
//            camera pclk domain, frames on vsync/href, assembles byte pairs
//            into RGB565 (DATA_W=16) or RGB444 (DATA_W=12) pixels, applies a
//            per-frame 1x/2x/4x decimation and emits linear frame-buffer
//            writes plus frame status.
// Ports    : pclk        - camera pixel clock (only clock)
//            rst         - asynchronous reset, active low
//            en          - capture enable, honoured at frame boundaries
//            decim[1:0]  - 0=1x, 1=2x, 2=4x, 3=4x; latched at frame start
//            vsync/href  - camera sync (vsync high = blanking, href high =
//                          valid line bytes)
//            d[7:0]      - camera data byte
//            addr        - frame-buffer write address
//            dout        - pixel data
//            we          - write strobe, one pclk per stored pixel
//            frame_done  - one-cycle pulse at the end of a captured frame
//            frame_cnt   - captured-frame counter (wraps)
//            overflow    - sticky for the frame: a kept pixel was dropped
//                          because the address limit was reached
// Options  : `define FRAME_STATS_EN adds line_count, pix_per_line and
//            size_err (frame geometry check latched at frame_done).
// Notes    : DATA_W must be 12 or 16; H_ACTIVE and V_ACTIVE must be >= 4.
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12,
  parameter int MAX_PIX  = 307200
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        decim,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              we,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              overflow
`ifdef FRAME_STATS_EN
  ,
  output logic [11:0]       line_count,
  output logic [11:0]       pix_per_line,
  output logic              size_err
`endif
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_PIX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_ARM   = 2'd2;
  localparam logic [1:0] S_FRAME = 2'd3;

  // Input stage and one-cycle-delayed copies for edge detection
  logic       vsync_r, href_r, vsync_rd, href_rd;
  logic [7:0] d_r;
  logic [7:0] hi;        // first (high) byte of the pixel being assembled
  logic       phase;     // 1 = byte now in the input stage is the low byte
  logic [1:0] state;
  logic [1:0] mask;      // decimation mask latched at frame start
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic       full;      // last address already written this frame

  logic vs_rise, vs_fall, href_fall, pix_now, keep;
  logic [DATA_W-1:0] pix;

  assign vs_rise   = vsync_r & ~vsync_rd;
  assign vs_fall   = ~vsync_r & vsync_rd;
  assign href_fall = ~href_r & href_rd;
  // A pixel completes when the low byte sits in the input stage of an
  // active (non-blanking) line of a frame being captured.
  assign pix_now   = (state == S_FRAME) & ~vsync_r & href_r & phase;
  assign keep      = ((x & XW'(mask)) == '0) && ((y & YW'(mask)) == '0);

  generate
    if (DATA_W == 16) begin : g_rgb565
      assign pix = {hi, d_r};
    end else begin : g_rgb444
      // Keep the top 4 bits of each RGB565 field
      logic unused_bits;
      assign unused_bits = ^{hi[3], d_r[6:5], d_r[0]};
      assign pix = {hi[7:4], hi[2:0], d_r[7], d_r[4:1]};
    end
  endgenerate

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_r    <= 1'b0;
      href_r     <= 1'b0;
      vsync_rd   <= 1'b0;
      href_rd    <= 1'b0;
      d_r        <= 8'd0;
      hi         <= 8'd0;
      phase      <= 1'b0;
      state      <= S_IDLE;
      mask       <= 2'd0;
      x          <= '0;
      y          <= '0;
      full       <= 1'b0;
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      overflow   <= 1'b0;
    end else begin
      vsync_r  <= vsync;
      href_r   <= href;
      d_r      <= d;
      vsync_rd <= vsync_r;
      href_rd  <= href_r;

      // Phase is zero whenever href_r is low, so every line starts on the
      // high byte and a dangling high byte is simply forgotten.
      phase <= href_r ? ~phase : 1'b0;
      if (href_r && !phase) begin
        hi <= d_r;
      end

      we         <= 1'b0;
      frame_done <= 1'b0;

      // Address advances the cycle after the write; the last address is
      // held once used so the frame buffer is never written past its end.
      if (we) begin
        if (addr == ADDR_LAST) begin
          full <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (vs_rise) begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (vs_fall) begin
            state    <= S_FRAME;
            mask     <= (decim == 2'd0) ? 2'b00 : ((decim == 2'd1) ? 2'b01 : 2'b11);
            x        <= '0;
            y        <= '0;
            addr     <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_FRAME: begin
          if (vs_rise) begin
            // The rising edge that ends this frame also serves as the
            // sync edge for the next one, so re-arm directly.
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= en ? S_ARM : S_IDLE;
          end else if (!vsync_r) begin
            if (href_fall) begin
              x <= '0;
              if (y != Y_MAX) begin
                y <= y + YW'(1);
              end
            end else if (pix_now) begin
              if (x != X_MAX) begin
                x <= x + XW'(1);
              end
              if (keep) begin
                if (full) begin
                  overflow <= 1'b1;
                end else begin
                  we   <= 1'b1;
                  dout <= pix;
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_STATS_EN
  logic [11:0] line_cnt_q, pix_cnt_q, last_line_pix;
  logic        shape_bad;  // some completed line had the wrong pixel count

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      line_cnt_q    <= 12'd0;
      pix_cnt_q     <= 12'd0;
      last_line_pix <= 12'd0;
      shape_bad     <= 1'b0;
      line_count    <= 12'd0;
      pix_per_line  <= 12'd0;
      size_err      <= 1'b0;
    end else begin
      size_err <= 1'b0;
      if (state == S_ARM && vs_fall) begin
        line_cnt_q    <= 12'd0;
        pix_cnt_q     <= 12'd0;
        last_line_pix <= 12'd0;
        shape_bad     <= 1'b0;
      end else if (state == S_FRAME) begin
        if (vs_rise) begin
          line_count   <= line_cnt_q;
          pix_per_line <= last_line_pix;
          // A line still in progress at vsync is an aborted line
          size_err     <= (line_cnt_q != 12'(V_ACTIVE)) || shape_bad ||
                          (pix_cnt_q != 12'd0);
        end else if (!vsync_r) begin
          if (href_fall) begin
            if (line_cnt_q != 12'hFFF) begin
              line_cnt_q <= line_cnt_q + 12'd1;
            end
            last_line_pix <= pix_cnt_q;
            pix_cnt_q     <= 12'd0;
            if (pix_cnt_q != 12'(H_ACTIVE)) begin
              shape_bad <= 1'b1;
            end
          end else if (pix_now && pix_cnt_q != 12'hFFF) begin
            pix_cnt_q <= pix_cnt_q + 12'd1;
          end
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture_ctrl
// Purpose  : Self-checking bench for cam_capture_ctrl. Two instances (RGB565
//            with a frame-sized buffer, RGB444 with a small buffer) share one
//            directed camera stimulus. A frame-level model schedules the
//            expected writes, frame pulses and overflow changes per cycle;
//            one compare process checks them every cycle, and literal
//            expectations pin write counts, first-pixel values and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture_ctrl;
  localparam int H = 16, V = 8, AW = 8, NCYC = 4096;
  localparam int MAX16 = 128, MAX12 = 100;

  logic pclk = 1'b0;
  logic rst, en, vsync, href;
  logic [1:0] decim;
  logic [7:0] d;
  logic [AW-1:0] addr16, addr12;
  logic [15:0] dout16;
  logic [11:0] dout12;
  logic we16, we12, fd16, fd12, ovf16, ovf12;
  logic [7:0] fc16, fc12;
`ifdef FRAME_STATS_EN
  logic [11:0] lc16, ppl16, lc12, ppl12;
  logic se16, se12;
`endif

  always #5 pclk = ~pclk;

  cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(16), .MAX_PIX(MAX16)) dut16 (
    .pclk(pclk), .rst(rst), .en(en), .decim(decim), .vsync(vsync), .href(href), .d(d),
    .addr(addr16), .dout(dout16), .we(we16), .frame_done(fd16), .frame_cnt(fc16), .overflow(ovf16)
`ifdef FRAME_STATS_EN
    , .line_count(lc16), .pix_per_line(ppl16), .size_err(se16)
`endif
  );

  cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(12), .MAX_PIX(MAX12)) dut12 (
    .pclk(pclk), .rst(rst), .en(en), .decim(decim), .vsync(vsync), .href(href), .d(d),
    .addr(addr12), .dout(dout12), .we(we12), .frame_done(fd12), .frame_cnt(fc12), .overflow(ovf12)
`ifdef FRAME_STATS_EN
    , .line_count(lc12), .pix_per_line(ppl12), .size_err(se12)
`endif
  );

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model (index 0 = RGB565, 1 = RGB444) ------
  bit          e_we   [2][NCYC];
  int          e_addr [2][NCYC];
  logic [15:0] e_pix  [2][NCYC];
  bit          e_oset [2][NCYC];
  bit          e_oclr [2][NCYC];
  bit          e_fd   [NCYC];
  bit capturing = 0, armed = 0;
  int step = 1;
  int maddr [2];
  bit mfull [2];
  int t_b0 = -100;

  function automatic int maxp(input int k);
    return (k == 0) ? MAX16 : MAX12;
  endfunction

  // RGB565 -> RGB444 by dropping the low bits of each colour field
  function automatic logic [11:0] to444(input logic [15:0] p);
    logic [4:0] r; logic [5:0] g; logic [4:0] b;
    r = p[15:11]; g = p[10:5]; b = p[4:0];
    return {r[4:1], g[5:2], b[4:1]};
  endfunction

  function automatic logic [7:0] mkbyte(input int f, input int l, input int b);
    int i;
    i = b / 2;
    if (f == 0 && l == 0 && i == 0) return (b % 2 == 1) ? 8'h1F : 8'hF8;
    if (b % 2 == 0) return 8'(f * 37 + l * 11 + i * 3 + 5);
    return 8'(i * 29 + l * 5 + f * 13) ^ 8'hA5;
  endfunction

  // Low byte of pixel i of line l was put on the pins in cycle n
  task automatic model_pixel(input int l, input int i, input int n, input logic [15:0] p);
    int x, y, t;
    t = n + 2;
    if (!capturing || t >= NCYC) return;
    x = (i < H) ? i : H - 1;
    y = (l < V) ? l : V - 1;
    if ((x % step) != 0 || (y % step) != 0) return;
    for (int k = 0; k < 2; k++) begin
      if (mfull[k]) e_oset[k][t] = 1'b1;
      else begin
        e_we[k][t] = 1'b1; e_addr[k][t] = maddr[k]; e_pix[k][t] = p;
        maddr[k]++;
        if (maddr[k] == maxp(k)) mfull[k] = 1'b1;
      end
    end
  endtask

  task automatic vs_rise_model(input int n);
    if (capturing && n + 2 < NCYC) e_fd[n + 2] = 1'b1;
    capturing = 0;
    armed = en;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic send_byte(input int f, input int l, input int b);
    tick(); href = 1'b1; d = mkbyte(f, l, b);
    if (b % 2 == 1) begin
      model_pixel(l, b / 2, cyc, {mkbyte(f, l, b - 1), d});
      if (f == 0 && l == 0 && b == 1) t_b0 = cyc;
    end
  endtask

  task automatic send_line(input int f, input int l, input int nb);
    for (int b = 0; b < nb; b++) send_byte(f, l, b);
    tick(); href = 1'b0; d = 8'h3C;
    repeat (3) tick();
  endtask

  task automatic end_frame();
    tick(); vsync = 1'b1; vs_rise_model(cyc);
    repeat (3) tick();
  endtask

  task automatic start_frame();
    int de;
    tick(); vsync = 1'b0;
    if (armed) begin
      de = (decim == 2'd3) ? 2 : int'(decim);
      step = 1 << de;
      capturing = 1; armed = 0;
      for (int k = 0; k < 2; k++) begin
        maddr[k] = 0; mfull[k] = 1'b0;
        if (cyc + 2 < NCYC) e_oclr[k][cyc + 2] = 1'b1;
      end
    end
    repeat (3) tick();
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_on = 0;
  logic exp_ovf [2] = '{1'b0, 1'b0};
  logic [7:0] exp_fc = 8'd0;

  always @(negedge pclk) begin
    if (chk_on && cyc < NCYC) begin
      if (e_fd[cyc]) exp_fc = exp_fc + 8'd1;
      for (int k = 0; k < 2; k++) begin
        if (e_oclr[k][cyc]) exp_ovf[k] = 1'b0;
        if (e_oset[k][cyc]) exp_ovf[k] = 1'b1;
      end
      chk("we16", we16, e_we[0][cyc]);
      if (e_we[0][cyc]) begin
        chk("addr16", addr16, e_addr[0][cyc]);
        chk("dout16", dout16, e_pix[0][cyc]);
      end
      chk("we12", we12, e_we[1][cyc]);
      if (e_we[1][cyc]) begin
        chk("addr12", addr12, e_addr[1][cyc]);
        chk("dout12", dout12, to444(e_pix[1][cyc]));
      end
      chk("frame_done16", fd16, e_fd[cyc]);
      chk("frame_done12", fd12, e_fd[cyc]);
      chk("frame_cnt16", fc16, exp_fc);
      chk("frame_cnt12", fc12, exp_fc);
      chk("overflow16", ovf16, exp_ovf[0]);
      chk("overflow12", ovf12, exp_ovf[1]);
    end
  end

  // ---------------- records for literal expectations ----------------
  int wc16 [8], wc12 [8], cur16 = 0, cur12 = 0, fidx = 0;
  bit serr [8];
  int lcnt [8];
  int first_cyc = -1;
  logic [15:0] first16 = '0;
  logic [11:0] first12 = '0;
  logic [AW-1:0] first_a = '1;
  bit got12 = 0;

  always @(negedge pclk) begin
    if (chk_on) begin
      if (we16) begin
        cur16++;
        if (first_cyc < 0) begin first_cyc = cyc; first16 = dout16; first_a = addr16; end
      end
      if (we12) begin
        cur12++;
        if (!got12) begin got12 = 1; first12 = dout12; end
      end
      if (fd16 && fidx < 8) begin
        wc16[fidx] = cur16; wc12[fidx] = cur12; cur16 = 0; cur12 = 0;
`ifdef FRAME_STATS_EN
        serr[fidx] = se16; lcnt[fidx] = int'(lc16);
`endif
        fidx++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int exp16 [5], exp12 [5];
    exp16 = '{128, 32, 8, 34, 116};
    exp12 = '{100, 32, 8, 34, 100};
    rst = 1'b0; en = 1'b0; decim = 2'd0; vsync = 1'b0; href = 1'b0; d = 8'd0;

    // Reset held with busy inputs: outputs stay zero
    for (int i = 0; i < 6; i++) begin
      tick(); vsync = i[0]; href = ~i[0]; d = 8'(i * 41 + 7); en = i[1];
      @(negedge pclk);
      chk("rst_outs16_a", {addr16, dout16, we16, fd16}, 0);
      chk("rst_outs16_b", {fc16, ovf16}, 0);
      chk("rst_outs12", {addr12, dout12, we12, fd12, fc12, ovf12}, 0);
    end
    tick(); vsync = 1'b0; href = 1'b0; en = 1'b1; decim = 2'd0; rst = 1'b1; chk_on = 1;
    repeat (4) tick();

    // F0: full frame, 1x; RGB444 instance overflows at 100 pixels
    end_frame(); start_frame();
    for (int l = 0; l < V; l++) send_line(0, l, 2 * H);
    end_frame();
    @(negedge pclk);
    chk("f0_addr16_hold", addr16, MAX16 - 1);
    chk("f0_ovf16", ovf16, 0);
    chk("f0_addr12_hold", addr12, MAX12 - 1);
    chk("f0_ovf12", ovf12, 1);
    chk("f0_frame_cnt", fc16, 1);

    // F1: 2x, decim changed mid-frame, over-long first line
    decim = 2'd1; start_frame();
    send_line(1, 0, 2 * H + 8);
    for (int l = 1; l < 4; l++) send_line(1, l, 2 * H);
    decim = 2'd2;
    for (int l = 4; l < V; l++) send_line(1, l, 2 * H);
    end_frame(); start_frame();

    // F2: 4x, enable dropped mid-frame
    for (int l = 0; l < 4; l++) send_line(2, l, 2 * H);
    en = 1'b0;
    for (int l = 4; l < V; l++) send_line(2, l, 2 * H);
    end_frame(); start_frame();

    // F3: not captured; enable returns mid-frame
    for (int l = 0; l < 4; l++) send_line(3, l, 2 * H);
    en = 1'b1; decim = 2'd0;
    for (int l = 4; l < V; l++) send_line(3, l, 2 * H);
    end_frame(); start_frame();

    // F4: vsync rises in the middle of line 2 (after a lone high byte)
    send_line(4, 0, 2 * H);
    send_line(4, 1, 2 * H);
    for (int b = 0; b < 5; b++) send_byte(4, 2, b);
    tick(); href = 1'b1; d = mkbyte(4, 2, 5); vsync = 1'b1; vs_rise_model(cyc);
    repeat (3) tick();
    tick(); href = 1'b0;
    repeat (2) tick();
    start_frame();

    // F5: odd byte count on line 1
    send_line(5, 0, 2 * H);
    send_line(5, 1, 9);
    for (int l = 2; l < V; l++) send_line(5, l, 2 * H);
    end_frame();
    repeat (5) tick();
    @(negedge pclk);

    chk("end_addr16", addr16, 116);
    chk("end_addr12", addr12, MAX12 - 1);
    chk("end_ovf12", ovf12, 1);
    chk("end_ovf16", ovf16, 0);
    chk("end_frame_cnt", fc16, 5);
    chk("frames_seen", fidx, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("writes16_f%0d", i), wc16[i], exp16[i]);
      chk($sformatf("writes12_f%0d", i), wc12[i], exp12[i]);
    end
    chk("first_we_latency", first_cyc - t_b0, 2);
    chk("first_dout16", first16, 16'hF81F);
    chk("first_dout12", first12, 12'hF0F);
    chk("first_addr", first_a, 0);
`ifdef FRAME_STATS_EN
    chk("f0_size_err", serr[0], 0);
    chk("f0_line_count", lcnt[0], V);
    chk("f1_size_err", serr[1], 1);
    chk("f2_size_err", serr[2], 0);
    chk("f4_size_err", serr[3], 1);
    chk("f4_line_count", lcnt[3], 2);
    chk("f5_size_err", serr[4], 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
